// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Optional CLK_DIV_SYNC_EN adds a phase-sync input to clk_div_prog.
package clk_div_pkg;

  localparam int          DEF_DIV_W = 8;
  localparam int          DEF_DIV   = 12;
  localparam int unsigned MIN_DIV   = 2;

  function automatic int unsigned hi_len(
    input int unsigned d
  );
    return d - (d >> 1);
  endfunction

  function automatic int unsigned clamp_div(
    input int unsigned d
  );
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Divisor load handshake: pending register, clamp and error pulse.
// The top signals apply when the pending value is taken at a wrap.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             apply,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             pending,
  output logic [DIV_W-1:0] pend_div
);

  logic accept;

  assign cfg_ready = ~pending;
  assign accept    = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      pend_div <= DIV_W'(MIN_DIV);
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= accept && (cfg_div < DIV_W'(MIN_DIV));
      if (accept) begin
        pending  <= 1'b1;
        pend_div <= DIV_W'(clamp_div(32'(cfg_div)));
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with tick output.
// Define CLK_DIV_SYNC_EN to add the sync_in phase-reset port.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] hi_nxt;
  logic [DIV_W-1:0] pend_div;
  logic             pending;
  logic             sync;
  logic             adv;
  logic             wrap;
  logic             apply;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  assign adv     = en | sync;
  assign wrap    = sync | (cnt == div_active - 1'b1);
  assign apply   = adv & wrap & pending;
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
  assign div_nxt = apply ? pend_div : div_active;
  assign hi_nxt  = DIV_W'(hi_len(32'(div_nxt)));

  clk_div_cfg #(
    .DIV_W (DIV_W)
  ) u_cfg (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .apply     (apply),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .pending   (pending),
    .pend_div  (pend_div)
  );

  // Duty compare uses the divisor of the period cnt_nxt belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= DIV_W'(DEFAULT_DIV - 1);
      div_active <= DIV_W'(DEFAULT_DIV);
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else if (adv) begin
      cnt        <= cnt_nxt;
      div_active <= div_nxt;
      clk_out    <= cnt_nxt < hi_nxt;
      tick       <= wrap;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog.
// Define CLK_DIV_SYNC_EN to also exercise sync_in.
module tb_clk_div_prog;

  logic       clk;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic [7:0] div_active;
  logic       clk_out;
  logic       tick;
`ifdef CLK_DIV_SYNC_EN
  logic       sync_in;
`endif

  int checks;
  int errors;
  int n;
  int highs;

  clk_div_prog dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
`ifdef CLK_DIV_SYNC_EN
    .sync_in    (sync_in),
`endif
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .div_active (div_active),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
`ifdef CLK_DIV_SYNC_EN
    sync_in   = 1'b0;
`endif
    step();
    step();
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_div", div_active, 12);
    chk("rst_err", cfg_err, 0);

    // default divide-by-12, first edge rises
    reset = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      chk("d12_clk", clk_out, (i % 12) < 6);
      chk("d12_tick", tick, (i % 12) == 0);
    end

    // load 5 at cnt=3; old period completes
    repeat (3) step();
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    step();
    chk("acc_ready", cfg_ready, 0);
    chk("acc_err", cfg_err, 0);
    chk("acc_div", div_active, 12);
    chk("acc_clk", clk_out, 1);
    cfg_div = 8'd9;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("old_clk", clk_out, (4 + i) < 6);
      chk("old_tick", tick, 0);
      chk("hold_ready", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("d5_clk", clk_out, (i % 5) < 3);
      chk("d5_tick", tick, (i % 5) == 0);
      chk("d5_div", div_active, 5);
      chk("d5_ready", cfg_ready, 1);
    end

    // divisor 0 clamps to 2, accepted in a wrap cycle
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    step();
    chk("err_pulse", cfg_err, 1);
    chk("err_ready", cfg_ready, 0);
    chk("err_tick", tick, 1);
    cfg_valid = 1'b0;
    step();
    chk("err_clear", cfg_err, 0);
    chk("err_clk", clk_out, 1);
    repeat (3) step();
    chk("late_clk", clk_out, 0);
    chk("late_div", div_active, 5);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("d2_clk", clk_out, (i % 2) == 0);
      chk("d2_tick", tick, (i % 2) == 0);
      chk("d2_div", div_active, 2);
      chk("d2_err", cfg_err, 0);
    end

    // back to 12, then freeze in the high phase
    cfg_valid = 1'b1;
    cfg_div   = 8'd12;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    chk("re12_div", div_active, 12);
    chk("re12_tick", tick, 1);
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("frz_clk", clk_out, 1);
      chk("frz_tick", tick, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("res_clk", clk_out, (i < 3) || (i == 9));
      chk("res_tick", tick, i == 9);
    end

    // reset discards a pending 255
    cfg_valid = 1'b1;
    cfg_div   = 8'd255;
    step();
    cfg_valid = 1'b0;
    chk("pend_ready", cfg_ready, 0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_div", div_active, 12);
    chk("rst2_ready", cfg_ready, 1);
    chk("rst2_clk", clk_out, 0);
    chk("rst2_tick", tick, 0);
    for (int i = 0; i < 13; i++) begin
      step();
      chk("r2_clk", clk_out, (i % 12) < 6);
      chk("r2_tick", tick, (i % 12) == 0);
      chk("r2_div", div_active, 12);
    end

    // maximum divisor 255: 128 high, 127 low
    cfg_valid = 1'b1;
    cfg_div   = 8'd255;
    step();
    cfg_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 40);
    chk("big_apply", n, 11);
    chk("big_div", div_active, 255);
    n     = 0;
    highs = 0;
    do begin
      step();
      n++;
      highs += int'(clk_out);
    end while (!tick && n < 300);
    chk("big_period", n, 255);
    chk("big_high", highs, 128);

`ifdef CLK_DIV_SYNC_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("sync_pre", clk_out, 1);
    sync_in = 1'b1;
    step();
    chk("sync_clk", clk_out, 1);
    chk("sync_tick", tick, 1);
    sync_in = 1'b0;
    step();
    chk("sync_next", tick, 0);
    en      = 1'b0;
    sync_in = 1'b1;
    step();
    chk("sync_en0", tick, 1);
    sync_in = 1'b0;
    step();
    chk("sync_hold", tick, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
